// File: rtl/iicmb_wb_sequencer.sv
// iicmb_wb_sequencer
// Wishbone master that drives the IICMB I2C controller (iicmb_m_wb) through its
// CSR/DPR/CMDR registers. It initialises the controller once after reset, then turns
// single-byte I2C requests into controller command steps and reports one response
// for each request.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_rnw                  1 = read, 0 = write
//   req_slave, req_reg       7-bit slave address, register byte
//   req_wdata                data byte for writes
//   rsp_valid                one-cycle response pulse
//   rsp_rdata, rsp_status    read data, 0 OK / 1 NAK / 2 arbitration lost / 3 error
//   cyc_o, stb_o, we_o,
//   adr_o, dat_o             registered Wishbone master outputs (adr 0 CSR, 1 DPR, 2 CMDR)
//   ack_i, dat_i             Wishbone acknowledge and read data
//   irq_i                    controller interrupt (command done)
module iicmb_wb_sequencer #(
   parameter int unsigned BUS_ID         = 0,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rnw,
   input  logic [6:0] req_slave,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [1:0] rsp_status,
   output logic       cyc_o,
   output logic       stb_o,
   output logic       we_o,
   output logic [1:0] adr_o,
   output logic [7:0] dat_o,
   input  logic       ack_i,
   input  logic [7:0] dat_i,
   input  logic       irq_i
);

   localparam logic [1:0] AdrCsr  = 2'd0;
   localparam logic [1:0] AdrDpr  = 2'd1;
   localparam logic [1:0] AdrCmdr = 2'd2;

   localparam logic [7:0] CsrEnable   = 8'hC0;
   localparam logic [7:0] CmdStart    = 8'h04;
   localparam logic [7:0] CmdStop     = 8'h05;
   localparam logic [7:0] CmdWrite    = 8'h01;
   localparam logic [7:0] CmdReadNack = 8'h03;
   localparam logic [7:0] CmdSetBus   = 8'h06;

   localparam logic [1:0] RspOk  = 2'd0;
   localparam logic [1:0] RspNak = 2'd1;
   localparam logic [1:0] RspAl  = 2'd2;
   localparam logic [1:0] RspErr = 2'd3;

   // Counter value on the last irq-less cycle before the timeout is declared
   localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      StInitCsr, StInitDpr, StInitSetbus, StIdle, StStart, StAddrW, StReg, StData,
      StRstart, StAddrR, StRead, StGetDpr, StStop, StResp
   } state_e;

   // Sub-steps inside a state: optional DPR write (or plain register access),
   // CMDR write, wait for irq, CMDR status read.
   typedef enum logic [1:0] {PhDpr, PhCmd, PhIrq, PhRd} phase_e;

   state_e      state_q;
   phase_e      phase_q;
   logic [15:0] tmo_cnt_q;
   logic [1:0]  stat_q;
   logic        rnw_q;
   logic [6:0]  slave_q;
   logic [7:0]  reg_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rdata_q;

   logic [7:0]  dpr_byte;
   logic [7:0]  cmd_byte;
   logic [1:0]  launch_adr;
   logic        launch_we;
   logic [7:0]  launch_dat;
   logic        tmo_hit;
   logic        step_fin;
   logic [1:0]  step_code;
   state_e      ok_next;
   state_e      fin_state;
   logic [1:0]  fin_stat;

   function automatic phase_e entry_phase(input state_e s);
      case (s)
         StInitSetbus, StStart, StRstart, StRead, StStop: return PhCmd;
         default:                                         return PhDpr;
      endcase
   endfunction

   // Status byte priority: NAK, then AL, then ERR, then DON
   function automatic logic [1:0] decode_status(input logic [7:0] s);
      if (s[6])      return RspNak;
      else if (s[5]) return RspAl;
      else if (s[4]) return RspErr;
      else if (s[7]) return RspOk;
      else           return RspErr;
   endfunction

   // Data and command bytes belonging to the current state
   always_comb begin
      dpr_byte = 8'h00;
      cmd_byte = CmdStop;
      unique case (state_q)
         StInitCsr:         dpr_byte = CsrEnable;
         StInitDpr:         dpr_byte = 8'(BUS_ID);
         StInitSetbus:      cmd_byte = CmdSetBus;
         StStart, StRstart: cmd_byte = CmdStart;
         StAddrW: begin
            dpr_byte = {slave_q, 1'b0};
            cmd_byte = CmdWrite;
         end
         StReg: begin
            dpr_byte = reg_q;
            cmd_byte = CmdWrite;
         end
         StData: begin
            dpr_byte = wdata_q;
            cmd_byte = CmdWrite;
         end
         StAddrR: begin
            dpr_byte = {slave_q, 1'b1};
            cmd_byte = CmdWrite;
         end
         StRead:            cmd_byte = CmdReadNack;
         default:           ;
      endcase
   end

   // Wishbone access to start when the bus is free
   always_comb begin
      launch_adr = AdrCmdr;
      launch_we  = 1'b1;
      launch_dat = cmd_byte;
      unique case (phase_q)
         PhDpr: begin
            launch_adr = (state_q == StInitCsr) ? AdrCsr : AdrDpr;
            launch_we  = (state_q != StGetDpr);
            launch_dat = (state_q == StGetDpr) ? 8'h00 : dpr_byte;
         end
         PhRd: begin
            launch_we  = 1'b0;
            launch_dat = 8'h00;
         end
         default: ;
      endcase
   end

   // Command step completion: status read acknowledged, or irq wait expired
   always_comb begin
      tmo_hit   = (tmo_cnt_q == TmoLast);
      step_fin  = 1'b0;
      step_code = RspOk;
      if (cyc_o && ack_i && phase_q == PhRd) begin
         step_fin  = 1'b1;
         step_code = decode_status(dat_i);
      end else if (!cyc_o && phase_q == PhIrq && !irq_i && tmo_hit) begin
         step_fin  = 1'b1;
         step_code = RspErr;
      end
   end

   always_comb begin
      unique case (state_q)
         StStart:  ok_next = StAddrW;
         StAddrW:  ok_next = StReg;
         StReg:    ok_next = rnw_q ? StRstart : StData;
         StData:   ok_next = StStop;
         StRstart: ok_next = StAddrR;
         StAddrR:  ok_next = StRead;
         StRead:   ok_next = StGetDpr;
         default:  ok_next = StStop;
      endcase
   end

   always_comb begin
      fin_state = state_q;
      fin_stat  = stat_q;
      unique case (state_q)
         StInitSetbus: fin_state = (step_code == RspOk) ? StIdle : StInitCsr;
         StStop: begin
            fin_state = StResp;
            // On a failure path the STOP outcome does not override the first error
            if (stat_q == RspOk) fin_stat = step_code;
         end
         default: begin
            if (step_code == RspOk) begin
               fin_state = ok_next;
            end else begin
               fin_stat  = step_code;
               fin_state = (step_code == RspAl) ? StResp : StStop;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StInitCsr;
         phase_q    <= PhDpr;
         tmo_cnt_q  <= 16'd0;
         stat_q     <= RspOk;
         rnw_q      <= 1'b0;
         slave_q    <= 7'd0;
         reg_q      <= 8'd0;
         wdata_q    <= 8'd0;
         rdata_q    <= 8'd0;
         cyc_o      <= 1'b0;
         stb_o      <= 1'b0;
         we_o       <= 1'b0;
         adr_o      <= 2'd0;
         dat_o      <= 8'd0;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 8'd0;
         rsp_status <= 2'd0;
      end else begin
         rsp_valid <= 1'b0;

         if (step_fin) begin
            state_q <= fin_state;
            phase_q <= entry_phase(fin_state);
            stat_q  <= fin_stat;
            if (fin_state == StResp) begin
               rsp_valid  <= 1'b1;
               rsp_status <= fin_stat;
               rsp_rdata  <= (fin_stat == RspOk) ? rdata_q : 8'h00;
            end
            if (fin_state == StIdle) req_ready <= 1'b1;
         end

         if (cyc_o) begin
            if (ack_i) begin
               // Drop the bus for at least one cycle after every access
               cyc_o <= 1'b0;
               stb_o <= 1'b0;
               we_o  <= 1'b0;
               adr_o <= 2'd0;
               dat_o <= 8'd0;
               unique case (phase_q)
                  PhDpr: begin
                     case (state_q)
                        StInitCsr: state_q <= StInitDpr;
                        StInitDpr: begin
                           state_q <= StInitSetbus;
                           phase_q <= PhCmd;
                        end
                        StGetDpr: begin
                           rdata_q <= dat_i;
                           state_q <= StStop;
                           phase_q <= PhCmd;
                        end
                        default:   phase_q <= PhCmd;
                     endcase
                  end
                  PhCmd: begin
                     tmo_cnt_q <= 16'd0;
                     phase_q   <= PhIrq;
                  end
                  default: ;
               endcase
            end
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (req_valid && req_ready) begin
                     rnw_q     <= req_rnw;
                     slave_q   <= req_slave;
                     reg_q     <= req_reg;
                     wdata_q   <= req_wdata;
                     rdata_q   <= 8'h00;
                     stat_q    <= RspOk;
                     req_ready <= 1'b0;
                     state_q   <= StStart;
                     phase_q   <= PhCmd;
                  end
               end
               StResp: begin
                  state_q   <= StIdle;
                  req_ready <= 1'b1;
               end
               default: begin
                  if (phase_q == PhIrq) begin
                     if (irq_i) begin
                        phase_q <= PhRd;
                     end else if (!tmo_hit) begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                     end
                  end else begin
                     cyc_o <= 1'b1;
                     stb_o <= 1'b1;
                     we_o  <= launch_we;
                     adr_o <= launch_adr;
                     dat_o <= launch_dat;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iicmb_wb_sequencer.sv
// Directed testbench for iicmb_wb_sequencer with a small behavioural model of the
// IICMB controller register interface (1-cycle ack, irq 3 cycles after a command).
module tb_iicmb_wb_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_rnw = 1'b0;
   logic [6:0] req_slave = 7'd0;
   logic [7:0] req_reg = 8'd0;
   logic [7:0] req_wdata = 8'd0;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_status;
   logic       cyc_o, stb_o, we_o;
   logic [1:0] adr_o;
   logic [7:0] dat_o;
   logic       ack_r;
   logic [7:0] dat_i;
   logic       irq_r;

   always #5 clk = ~clk;

   iicmb_wb_sequencer #(
      .BUS_ID         (0),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rnw    (req_rnw),
      .req_slave  (req_slave),
      .req_reg    (req_reg),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_status (rsp_status),
      .cyc_o      (cyc_o),
      .stb_o      (stb_o),
      .we_o       (we_o),
      .adr_o      (adr_o),
      .dat_o      (dat_o),
      .ack_i      (ack_r),
      .dat_i      (dat_i),
      .irq_i      (irq_r)
   );

   // Controller model knobs (written only by the stimulus block)
   logic [7:0] read_byte  = 8'h00;
   logic [7:0] nak_dpr    = 8'hFF;
   logic [7:0] al_dpr     = 8'hFF;
   logic       hang_start = 1'b0;

   logic [7:0]  cmd_stat;
   logic [7:0]  last_dpr;
   int          irq_dly;
   int          cyc_cnt = 0;
   logic [10:0] log_q[$];   // {we, adr, dat} of every completed access
   int          log_t[$];

   assign dat_i = (adr_o == 2'd2) ? cmd_stat : (adr_o == 2'd1) ? read_byte : 8'h00;

   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (rst) begin
         ack_r    <= 1'b0;
         irq_r    <= 1'b0;
         irq_dly  <= 0;
         cmd_stat <= 8'h00;
         last_dpr <= 8'h00;
      end else begin
         ack_r <= cyc_o && stb_o && !ack_r;
         if (irq_dly > 0) begin
            if (irq_dly == 1) irq_r <= 1'b1;
            irq_dly <= irq_dly - 1;
         end
         if (cyc_o && stb_o && ack_r) begin
            log_q.push_back({we_o, adr_o, dat_o});
            log_t.push_back(cyc_cnt);
            if (we_o && adr_o == 2'd1) last_dpr <= dat_o;
            if (we_o && adr_o == 2'd2) begin
               if (dat_o == 8'h01 && last_dpr == nak_dpr)     cmd_stat <= 8'h40;
               else if (dat_o == 8'h01 && last_dpr == al_dpr) cmd_stat <= 8'h20;
               else                                           cmd_stat <= 8'h80;
               if (!(hang_start && dat_o == 8'h04)) irq_dly <= 3;
            end
            if (!we_o && adr_o == 2'd2) irq_r <= 1'b0;
         end
      end
   end

   int          vectors = 0;
   int          miscompares = 0;
   int          base = 0;
   logic [10:0] exp_q[$];
   logic [1:0]  got_status;
   logic [7:0]  got_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_cmd(input logic [7:0] c);
      exp_q.push_back({1'b1, 2'd2, c});
      exp_q.push_back({1'b0, 2'd2, 8'h00});
   endtask

   task automatic exp_dpr(input logic [7:0] d);
      exp_q.push_back({1'b1, 2'd1, d});
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_len"}, 32'(log_q.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < log_q.size())
            chk($sformatf("%s_%0d", tag, i), 32'(log_q[base + i]), 32'(exp_q[i]));
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(req_ready), 32'd1);
   endtask

   task automatic do_req(input logic rnw, input logic [6:0] sl, input logic [7:0] rg,
                         input logic [7:0] wd);
      wait_ready("ready_before_req");
      base      = log_q.size();
      req_rnw   = rnw;
      req_slave = sl;
      req_reg   = rg;
      req_wdata = wd;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("ready_drop", 32'(req_ready), 32'd0);
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_seen", 32'(rsp_valid), 32'd1);
      got_status = rsp_status;
      got_rdata  = rsp_rdata;
      @(negedge clk);
      chk("rsp_width", 32'(rsp_valid), 32'd0);
      chk("ready_after_rsp", 32'(req_ready), 32'd1);
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_cyc", 32'(cyc_o), 32'd0);
      chk("rst_we", 32'(we_o), 32'd0);
      chk("rst_adr", 32'(adr_o), 32'd0);
      chk("rst_dat", 32'(dat_o), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp", {21'd0, rsp_valid, rsp_rdata, rsp_status}, 32'd0);

      // Init: first access on the cycle after reset release
      base = log_q.size();
      rst  = 1'b0;
      @(negedge clk);
      chk("first_access", {21'd0, cyc_o, stb_o, we_o, adr_o, dat_o}, {21'd0, 3'b111, 2'd0, 8'hC0});
      wait_ready("init_ready");
      exp_q.delete();
      exp_q.push_back({1'b1, 2'd0, 8'hC0});
      exp_dpr(8'h00);
      exp_cmd(8'h06);
      check_log("init");

      // Write 0x78 to reg 0x00 of slave 0x22
      do_req(1'b0, 7'h22, 8'h00, 8'h78);
      wait_rsp();
      exp_q.delete();
      exp_cmd(8'h04);
      exp_dpr(8'h44); exp_cmd(8'h01);
      exp_dpr(8'h00); exp_cmd(8'h01);
      exp_dpr(8'h78); exp_cmd(8'h01);
      exp_cmd(8'h05);
      check_log("wr");
      chk("wr_status", 32'(got_status), 32'd0);
      chk("wr_rdata", 32'(got_rdata), 32'h00);

      // Read reg 0xAA of slave 0x44, slave returns 0xAB
      read_byte = 8'hAB;
      do_req(1'b1, 7'h44, 8'hAA, 8'h00);
      wait_rsp();
      exp_q.delete();
      exp_cmd(8'h04);
      exp_dpr(8'h88); exp_cmd(8'h01);
      exp_dpr(8'hAA); exp_cmd(8'h01);
      exp_cmd(8'h04);
      exp_dpr(8'h89); exp_cmd(8'h01);
      exp_cmd(8'h03);
      exp_q.push_back({1'b0, 2'd1, 8'h00});
      exp_cmd(8'h05);
      check_log("rd");
      chk("rd_status", 32'(got_status), 32'd0);
      chk("rd_rdata", 32'(got_rdata), 32'hAB);

      // NAK on address byte: STOP then status 1, read data forced to zero
      nak_dpr = 8'h66;
      do_req(1'b1, 7'h33, 8'h10, 8'h00);
      wait_rsp();
      exp_q.delete();
      exp_cmd(8'h04);
      exp_dpr(8'h66); exp_cmd(8'h01);
      exp_cmd(8'h05);
      check_log("nak");
      chk("nak_status", 32'(got_status), 32'd1);
      chk("nak_rdata", 32'(got_rdata), 32'h00);
      nak_dpr = 8'hFF;

      // Timeout: START never raises irq
      hang_start = 1'b1;
      do_req(1'b0, 7'h22, 8'h01, 8'h02);
      wait_rsp();
      hang_start = 1'b0;
      exp_q.delete();
      exp_q.push_back({1'b1, 2'd2, 8'h04});
      exp_cmd(8'h05);
      check_log("tmo");
      chk("tmo_status", 32'(got_status), 32'd3);
      // 100 wait cycles, then launch, ack latency and logging of the STOP write
      if (log_q.size() >= base + 2)
         chk("tmo_delay", 32'(log_t[base + 1] - log_t[base]), 32'd103);

      // Reset during the DATA WRITE wait
      begin
         int n = 0;
         do_req(1'b0, 7'h22, 8'h00, 8'h78);
         while (log_q.size() < base + 10 && n < 2000) begin
            @(negedge clk);
            n++;
         end
         chk("mid_reach", 32'(log_q.size() - base), 32'd10);
         if (log_q.size() >= base + 10) begin
            chk("mid_data", 32'(log_q[base + 8]), {21'd0, 1'b1, 2'd1, 8'h78});
            chk("mid_cmd", 32'(log_q[base + 9]), {21'd0, 1'b1, 2'd2, 8'h01});
         end
      end
      rst = 1'b1;
      @(negedge clk);
      chk("mid_cyc", 32'(cyc_o), 32'd0);
      chk("mid_ready", 32'(req_ready), 32'd0);
      chk("mid_rsp", 32'(rsp_valid), 32'd0);
      base = log_q.size();
      rst  = 1'b0;
      wait_ready("reinit_ready");
      exp_q.delete();
      exp_q.push_back({1'b1, 2'd0, 8'hC0});
      exp_dpr(8'h00);
      exp_cmd(8'h06);
      check_log("reinit");

      // Arbitration lost on the register byte: no STOP, status 2
      al_dpr = 8'h55;
      do_req(1'b0, 7'h10, 8'h55, 8'h9C);
      wait_rsp();
      exp_q.delete();
      exp_cmd(8'h04);
      exp_dpr(8'h20); exp_cmd(8'h01);
      exp_dpr(8'h55); exp_cmd(8'h01);
      check_log("al");
      chk("al_status", 32'(got_status), 32'd2);
      chk("al_rdata", 32'(got_rdata), 32'h00);
      al_dpr = 8'hFF;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
